// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEFAULT = 32'hFFFF_FFF0;
    localparam int          FRAME_BITS      = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data.
// Latency: a push is visible on dout the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign dout  = mem[rptr[AW-1:0]];

    // A pop on the same edge frees the slot the push needs.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Snoops store bus for writes to TX_ADDR and serialises the bytes 8N1 on tx.
// Latency: tx drops for the start bit two edges after the store when idle.
// Backpressure: none upstream; stores that find the FIFO full are counted in drop_cnt.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] TX_ADDR  = TX_ADDR_DEFAULT,
    parameter int          BAUD_DIV = 16,
    parameter int          DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic        tx,
    output logic        fifo_full,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int             CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);

    uart_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic          hit;
    logic          pop;
    logic          baud_done;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          unused_wdata;

    assign unused_wdata = ^WriteDataM[31:8];

    assign hit       = MemWriteM && (DataAdrM == TX_ADDR);
    assign baud_done = (baud_cnt == BAUD_LAST);
    // The head byte is taken either from idle or at the very end of a stop bit.
    assign pop       = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
    assign busy      = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (hit),
        .pop   (pop),
        .din   (WriteDataM[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= 8'd0;
        end else if (hit && fifo_full && !pop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= START;
                        shreg    <= fifo_dout;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        tx       <= shreg[0];
                        shreg    <= shreg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            state <= START;
                            shreg <= fifo_dout;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that snoops the processor's memory-stage store bus alongside data memory. Stores to a single reserved address are queued as bytes in a small FIFO and serialized 8N1 on a `tx` pin. It runs on the same clock as the processor core and data memory, so program output is visible without a debugger.

## Interface
Parameters:
- `TX_ADDR`, default 32'hFFFF_FFF0: word address that is decoded as the TX data register.
- `BAUD_DIV`, default 16: clock cycles per UART bit. Legal range is ≥ 2.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: processor clock. Same clock as data memory.
- `reset`, input, 1: asynchronous, active-low reset.
- `MemWriteM`, input, 1: memory-stage store strobe.
- `DataAdrM`, input, 32: memory-stage address.
- `WriteDataM`, input, 32: memory-stage store data. Only bits [7:0] are used.
- `tx`, output, 1: serial line. Idles high.
- `fifo_full`, output, 1: FIFO holds `DEPTH` entries.
- `busy`, output, 1: a frame is in progress, or the FIFO is non-empty.
- `drop_cnt`, output, 8: saturating count of stores lost because the FIFO was full.

## Operation
- **Hit definition.** A hit is `MemWriteM && DataAdrM == TX_ADDR`, sampled on the rising edge of `clk`. All other bus traffic is ignored. This block never drives the bus.
- **Hit with space.** On a hit with the FIFO not full, `WriteDataM[7:0]` is pushed.
- **Hit while full.** On a hit with the FIFO full, the byte is discarded and `drop_cnt` increments, saturating at 8'hFF.
- **Pop and push on the same edge while full.** The pop frees a slot, the push is accepted, and there is no drop.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The head byte is popped into an 8-bit shift register and the baud counter is cleared.
  - START drives `tx`=0 for `BAUD_DIV` cycles, then goes to DATA.
  - DATA sends the shift register LSB-first, one bit per `BAUD_DIV` cycles. A 3-bit counter moves to STOP after bit 7.
  - STOP drives `tx`=1 for `BAUD_DIV` cycles. At the end of STOP:
    - FIFO non-empty: pop and go straight to START, giving back-to-back frames with no idle gap.
    - FIFO empty: go to IDLE.
- **Counter widths.** The baud counter is $clog2(`BAUD_DIV`) bits wide and counts 0..`BAUD_DIV`-1. FIFO pointers are $clog2(`DEPTH`)+1 bits wide and wrap naturally.
- **`tx` output.** `tx` is a registered output.
- **Reset.** Reset mid-frame aborts the frame immediately, empties the FIFO, and drives `tx` high. A partial frame is never resumed.

## Timing
- Reset values: `tx`=1, `fifo_full`=0, `busy`=0, `drop_cnt`=0, FSM in IDLE, FIFO empty.
- Hit at edge N with the FIFO empty and the FSM in IDLE:
  - The FSM pops at edge N+1.
  - `tx` goes low after edge N+1.
  - The frame occupies 10×`BAUD_DIV` cycles, so `tx` returns to idle after edge N+1+10×`BAUD_DIV`.
- `busy` rises after edge N. It falls after the STOP bit completes, provided the FIFO is empty.
- `fifo_full` and `drop_cnt` update on the same edge as the push or drop that changes them.
- There are no combinational paths from the bus inputs to any output.

## Structure
- **Shared package `mmio_pkg`:**
  - `TX_ADDR` default constant.
  - UART state enum: IDLE/START/DATA/STOP.
  - Frame length constant: 10 bits.
- **Sub-module `sync_fifo`:**
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Async active-low reset.
  - Show-ahead `dout`.
- **Top level.** Address decode, FSM, baud/bit counters, and `drop_cnt` live in `mmio_uart_tx`.

## Test plan
All scenarios use `BAUD_DIV`=4 and `DEPTH`=4.
- **Single byte.** Store 32'h0000_0041 to `TX_ADDR`.
  - `tx` is low after edge N+1 for 4 cycles, then sends bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 4 high cycles.
  - `busy` is low again 41 cycles after the store.
- **Address miss.** Store to `TX_ADDR`+4, and a load to `TX_ADDR` (`MemWriteM`=0). `tx` stays 1, `busy` stays 0, and the FIFO stays empty.
- **Back-to-back.** Store 8'h55 and then 8'hAA on consecutive cycles. Two contiguous 40-cycle frames appear with no idle cycle between the STOP of the first and the START of the second.
- **Overflow.** Issue 6 consecutive stores while the first frame is in flight.
  - One byte is transmitting, 4 are queued, and `fifo_full`=1.
  - The 6th store gives `drop_cnt`=1.
  - Exactly 5 frames are transmitted, in order.
- **Simultaneous pop and push while full.** With the FIFO full, a store lands on the end-of-STOP edge. The store is accepted, `drop_cnt` is unchanged, and `fifo_full` stays 1.
- **Reset mid-frame.** Assert `reset` during DATA bit 3.
  - `tx`=1 and all outputs return to reset values asynchronously.
  - After reset is released, no residual frame is emitted.
